// File: rtl/mmu_tlb_if.sv
// Request/response and page-walk handshake bundle between the TLB and its neighbours.
// slave = TLB view, master = requester/walker view.
interface mmu_tlb_if #(
    parameter int VPN_W = 20,
    parameter int PPN_W = 20
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      vaddr;
    logic [1:0]       acc_type;
    logic [1:0]       cur_priv;
    logic             resp_valid;
    logic [31:0]      paddr;
    logic             page_perm_r;
    logic             page_perm_w;
    logic             page_perm_x;
    logic             page_user;
    logic             resp_fault;
    logic             walk_req_valid;
    logic             walk_req_ready;
    logic [VPN_W-1:0] walk_vpn;
    logic             walk_rsp_valid;
    logic [PPN_W-1:0] walk_ppn;
    logic             walk_r;
    logic             walk_w;
    logic             walk_x;
    logic             walk_u;
    logic             walk_err;

    modport slave (
        input  req_valid, vaddr, acc_type, cur_priv,
        input  walk_req_ready, walk_rsp_valid, walk_ppn,
        input  walk_r, walk_w, walk_x, walk_u, walk_err,
        output req_ready, resp_valid, paddr,
        output page_perm_r, page_perm_w, page_perm_x, page_user, resp_fault,
        output walk_req_valid, walk_vpn
    );

    modport master (
        output req_valid, vaddr, acc_type, cur_priv,
        output walk_req_ready, walk_rsp_valid, walk_ppn,
        output walk_r, walk_w, walk_x, walk_u, walk_err,
        input  req_ready, resp_valid, paddr,
        input  page_perm_r, page_perm_w, page_perm_x, page_user, resp_fault,
        input  walk_req_valid, walk_vpn
    );
endinterface

// File: rtl/mmu_tlb.sv
// Fully associative TLB with round-robin refill over a valid/ready walk port; hit/bypass respond at accept+1.
// Misses add walk latency + 2; req_ready is low while a miss is outstanding and responses cannot be stalled.
module mmu_tlb #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 20,
    parameter int PPN_W   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] csr_satp_q,
    input  logic        flush,
    mmu_tlb_if.slave    bus
);
    localparam int PTR_W = $clog2(ENTRIES);

    typedef struct packed {
        logic [VPN_W-1:0] tag;
        logic [PPN_W-1:0] ppn;
        logic             r;
        logic             w;
        logic             x;
        logic             u;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WALK, WAIT, RESP} state_t;

    state_t             state_q;
    state_t             state_d;
    entry_t             ent_q [ENTRIES];
    logic [ENTRIES-1:0] vld_q;
    logic [PTR_W-1:0]   ptr_q;

    logic [31:0]        vaddr_q;
    logic [1:0]         acc_q;
    logic [1:0]         priv_q;
    logic               flushed_q;

    logic               resp_valid_q;
    logic [31:0]        paddr_q;
    logic               r_q;
    logic               w_q;
    logic               x_q;
    logic               u_q;
    logic               fault_q;

    logic               accept;
    logic               bypass;
    logic               hit;
    logic               walk_done;
    logic               fill_en;
    entry_t             hit_ent;
    entry_t             fill_ent;
    logic [VPN_W-1:0]   req_vpn;
    logic               unused_satp;

    function automatic logic perm_fault(input logic [1:0] acc, input logic [1:0] priv,
                                        input logic r, input logic w, input logic x, input logic u);
        return ((acc == 2'd0) && !r) || ((acc == 2'd1) && !w) || ((acc == 2'd2) && !x) ||
               ((priv == 2'd0) && !u) || ((priv == 2'd1) && u && (acc == 2'd2));
    endfunction

    assign unused_satp = ^csr_satp_q[30:0];
    assign req_vpn     = bus.vaddr[12 +: VPN_W];
    assign bypass      = !csr_satp_q[31] || (bus.cur_priv == 2'd3);

    // Tags are unique by construction, so the last match is the only match.
    always_comb begin
        hit     = 1'b0;
        hit_ent = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (vld_q[i] && (ent_q[i].tag == req_vpn)) begin
                hit     = 1'b1;
                hit_ent = ent_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (!bypass && !hit) state_d = WALK;
                end
            end
            WALK:    if (bus.walk_req_ready) state_d = WAIT;
            WAIT:    if (bus.walk_rsp_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.walk_req_valid = (state_q == WALK);
    assign bus.walk_vpn       = vaddr_q[12 +: VPN_W];
    assign walk_done          = (state_q == WAIT) && bus.walk_rsp_valid;
    assign fill_en            = walk_done && !bus.walk_err && !flushed_q;

    // W^X: a writable page never keeps execute permission.
    always_comb begin
        fill_ent.tag = vaddr_q[12 +: VPN_W];
        fill_ent.ppn = bus.walk_ppn;
        fill_ent.r   = bus.walk_r;
        fill_ent.w   = bus.walk_w;
        fill_ent.x   = bus.walk_x && !bus.walk_w;
        fill_ent.u   = bus.walk_u;
    end

    always_ff @(posedge clk) begin
        if (fill_en) ent_q[ptr_q] <= fill_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            ptr_q        <= '0;
            vaddr_q      <= '0;
            acc_q        <= '0;
            priv_q       <= '0;
            flushed_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            paddr_q      <= '0;
            r_q          <= 1'b0;
            w_q          <= 1'b0;
            x_q          <= 1'b0;
            u_q          <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (accept) begin
                vaddr_q   <= bus.vaddr;
                acc_q     <= bus.acc_type;
                priv_q    <= bus.cur_priv;
                flushed_q <= 1'b0;
                if (bypass) begin
                    resp_valid_q <= 1'b1;
                    paddr_q      <= bus.vaddr;
                    {r_q, w_q, x_q, u_q} <= 4'b1111;
                    fault_q      <= 1'b0;
                end else if (hit) begin
                    resp_valid_q <= 1'b1;
                    paddr_q      <= 32'({hit_ent.ppn, bus.vaddr[11:0]});
                    {r_q, w_q, x_q, u_q} <= {hit_ent.r, hit_ent.w, hit_ent.x, hit_ent.u};
                    fault_q      <= perm_fault(bus.acc_type, bus.cur_priv,
                                               hit_ent.r, hit_ent.w, hit_ent.x, hit_ent.u);
                end
            end else if (flush && (state_q != IDLE)) begin
                // The walk still completes and responds, but its result must not be cached.
                flushed_q <= 1'b1;
            end

            if (walk_done) begin
                resp_valid_q <= 1'b1;
                if (bus.walk_err) begin
                    paddr_q <= 32'({bus.walk_vpn, vaddr_q[11:0]});
                    {r_q, w_q, x_q, u_q} <= 4'b0000;
                    fault_q <= 1'b1;
                end else begin
                    paddr_q <= 32'({bus.walk_ppn, vaddr_q[11:0]});
                    {r_q, w_q, x_q, u_q} <= {fill_ent.r, fill_ent.w, fill_ent.x, fill_ent.u};
                    fault_q <= perm_fault(acc_q, priv_q,
                                          fill_ent.r, fill_ent.w, fill_ent.x, fill_ent.u);
                end
            end

            if (flush) begin
                vld_q <= '0;
                ptr_q <= '0;
            end else if (fill_en) begin
                vld_q[ptr_q] <= 1'b1;
                ptr_q        <= ptr_q + PTR_W'(1);
            end
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.paddr       = paddr_q;
    assign bus.page_perm_r = r_q;
    assign bus.page_perm_w = w_q;
    assign bus.page_perm_x = x_q;
    assign bus.page_user   = u_q;
    assign bus.resp_fault  = fault_q;
endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: vector table plus hand sequences for eviction, flush and reset corners.
module tb_mmu_tlb;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] satp;
    logic        flush;
    int          total = 0;
    int          bad   = 0;

    mmu_tlb_if #(.VPN_W(20), .PPN_W(20)) bus ();

    mmu_tlb #(.ENTRIES(8), .VPN_W(20), .PPN_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_satp_q (satp),
        .flush      (flush),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sat;
        logic [31:0] va;
        logic [1:0]  acc;
        logic [1:0]  priv;
        logic        exp_walk;
        logic [19:0] w_ppn;
        logic [3:0]  w_rwxu;
        logic        w_err;
        logic [31:0] exp_pa;
        logic [3:0]  exp_rwxu;
        logic        exp_fault;
        logic        fl_acc;
        logic        fl_wait;
        logic        fl_rsp;
    } vec_t;

    vec_t vt [13];

    function automatic vec_t mk(input string nm, input logic sat, input logic [31:0] va,
                                input logic [1:0] acc, input logic [1:0] priv, input logic ew,
                                input logic [19:0] ppn, input logic [3:0] wp, input logic err,
                                input logic [31:0] pa, input logic [3:0] rwxu, input logic flt,
                                input logic fa = 1'b0, input logic fw = 1'b0, input logic fr = 1'b0);
        vec_t v;
        v.name = nm; v.sat = sat; v.va = va; v.acc = acc; v.priv = priv;
        v.exp_walk = ew; v.w_ppn = ppn; v.w_rwxu = wp; v.w_err = err;
        v.exp_pa = pa; v.exp_rwxu = rwxu; v.exp_fault = flt;
        v.fl_acc = fa; v.fl_wait = fw; v.fl_rsp = fr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc;
        bit          got;
        bit          walked;
        bit          vpn_ok;
        logic [19:0] vpn_seen;
        logic [19:0] exp_vpn;
        exp_vpn = v.va[31:12];
        vpn_seen = '0;
        chk({v.name, "_ready"}, bus.req_ready, 1);
        satp          = {v.sat, 31'h2A5};
        bus.req_valid = 1'b1;
        bus.vaddr     = v.va;
        bus.acc_type  = v.acc;
        bus.cur_priv  = v.priv;
        flush         = v.fl_acc;
        tick();
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        bus.vaddr     = ~v.va;
        satp          = {~v.sat, 31'h0};
        got = 1'b0; walked = 1'b0; vpn_ok = 1'b1; cyc = 1;
        while (!got && cyc < 50) begin
            if (bus.resp_valid) begin
                got = 1'b1;
            end else if (bus.walk_req_valid && !walked) begin
                walked   = 1'b1;
                vpn_seen = bus.walk_vpn;
                repeat (2) begin
                    tick(); cyc++;
                    if (!bus.walk_req_valid || bus.walk_vpn !== vpn_seen) vpn_ok = 1'b0;
                end
                bus.walk_req_ready = 1'b1;
                tick(); cyc++;
                bus.walk_req_ready = 1'b0;
                if (bus.walk_req_valid) vpn_ok = 1'b0;
                if (v.fl_wait) begin
                    flush = 1'b1;
                    tick(); cyc++;
                    flush = 1'b0;
                end
                bus.walk_rsp_valid = 1'b1;
                bus.walk_ppn       = v.w_ppn;
                {bus.walk_r, bus.walk_w, bus.walk_x, bus.walk_u} = v.w_rwxu;
                bus.walk_err       = v.w_err;
                flush              = v.fl_rsp;
                tick(); cyc++;
                bus.walk_rsp_valid = 1'b0;
                flush              = 1'b0;
            end else begin
                tick(); cyc++;
            end
        end
        chk({v.name, "_resp"}, got, 1);
        chk({v.name, "_walk"}, walked, v.exp_walk);
        if (walked) begin
            chk({v.name, "_vpn"}, vpn_seen, exp_vpn);
            chk({v.name, "_vpn_hold"}, vpn_ok, 1);
        end else begin
            chk({v.name, "_lat"}, cyc, 1);
        end
        chk({v.name, "_pa"}, bus.paddr, v.exp_pa);
        chk({v.name, "_rwxu"}, {bus.page_perm_r, bus.page_perm_w, bus.page_perm_x, bus.page_user},
            v.exp_rwxu);
        chk({v.name, "_fault"}, bus.resp_fault, v.exp_fault);
        tick();
        chk({v.name, "_pulse"}, bus.resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; satp = '0;
        bus.req_valid = 1'b0; bus.vaddr = '0; bus.acc_type = '0; bus.cur_priv = '0;
        bus.walk_req_ready = 1'b0; bus.walk_rsp_valid = 1'b0; bus.walk_ppn = '0;
        bus.walk_r = 1'b0; bus.walk_w = 1'b0; bus.walk_x = 1'b0; bus.walk_u = 1'b0;
        bus.walk_err = 1'b0;

        vt[0]  = mk("bypass_off",     1'b0, 32'h12345678, 2'd0, 2'd0, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h12345678, 4'b1111, 1'b0);
        vt[1]  = mk("bypass_m",       1'b1, 32'hDEADB00F, 2'd2, 2'd3, 1'b0, 20'h0,     4'b0000, 1'b0, 32'hDEADB00F, 4'b1111, 1'b0);
        vt[2]  = mk("miss_u_load",    1'b1, 32'h00400010, 2'd0, 2'd0, 1'b1, 20'h80001, 4'b1001, 1'b0, 32'h80001010, 4'b1001, 1'b0);
        vt[3]  = mk("hit_u_load",     1'b1, 32'h00400ABC, 2'd0, 2'd0, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h80001ABC, 4'b1001, 1'b0);
        vt[4]  = mk("hit_u_store",    1'b1, 32'h00400004, 2'd1, 2'd0, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h80001004, 4'b1001, 1'b1);
        vt[5]  = mk("wx_fetch",       1'b1, 32'h00500100, 2'd2, 2'd1, 1'b1, 20'h12345, 4'b1110, 1'b0, 32'h12345100, 4'b1100, 1'b1);
        vt[6]  = mk("wx_store",       1'b1, 32'h00500200, 2'd1, 2'd1, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h12345200, 4'b1100, 1'b0);
        vt[7]  = mk("s_fetch_upage",  1'b1, 32'h00600000, 2'd2, 2'd1, 1'b1, 20'h00777, 4'b1011, 1'b0, 32'h00777000, 4'b1011, 1'b1);
        vt[8]  = mk("u_fetch_upage",  1'b1, 32'h00600008, 2'd2, 2'd0, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h00777008, 4'b1011, 1'b0);
        vt[9]  = mk("u_load_spage",   1'b1, 32'h00500010, 2'd0, 2'd0, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h12345010, 4'b1100, 1'b1);
        vt[10] = mk("walk_err",       1'b1, 32'h00700ABC, 2'd0, 2'd1, 1'b1, 20'h0AAAA, 4'b1111, 1'b1, 32'h00700ABC, 4'b0000, 1'b1);
        vt[11] = mk("refill_aft_err", 1'b1, 32'h00700ABC, 2'd0, 2'd1, 1'b1, 20'h0AAAA, 4'b1100, 1'b0, 32'h0AAAAABC, 4'b1100, 1'b0);
        vt[12] = mk("bypass_again",   1'b0, 32'h00400010, 2'd0, 2'd0, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h00400010, 4'b1111, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_walk_req", bus.walk_req_valid, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_perms", {bus.page_perm_r, bus.page_perm_w, bus.page_perm_x, bus.page_user}, 0);
        chk("rst_fault", bus.resp_fault, 0);

        for (int i = 0; i < 13; i++) run_vec(vt[i]);

        // Flush, then fill VPN 0..8: VPN 8 wraps into slot 0 and evicts VPN 0.
        flush = 1'b1; tick(); flush = 1'b0;
        run_vec(mk("miss_after_flush", 1'b1, 32'h00400010, 2'd0, 2'd0, 1'b1, 20'h80002, 4'b1001, 1'b0, 32'h80002010, 4'b1001, 1'b0));
        flush = 1'b1; tick(); flush = 1'b0;
        for (int k = 0; k < 9; k++) begin
            logic [19:0] kv;
            kv = k[19:0];
            run_vec(mk($sformatf("fill_vpn%0d", k), 1'b1, {kv, 12'h024}, 2'd0, 2'd1, 1'b1,
                       20'h10000 + kv, 4'b1000, 1'b0, {20'h10000 + kv, 12'h024}, 4'b1000, 1'b0));
        end
        run_vec(mk("evicted_vpn0", 1'b1, 32'h00000024, 2'd0, 2'd1, 1'b1, 20'h20000, 4'b1000, 1'b0, 32'h20000024, 4'b1000, 1'b0));
        run_vec(mk("kept_vpn8",    1'b1, 32'h00008024, 2'd0, 2'd1, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h10008024, 4'b1000, 1'b0));
        run_vec(mk("kept_vpn2",    1'b1, 32'h00002024, 2'd0, 2'd1, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h10002024, 4'b1000, 1'b0));

        run_vec(mk("flush_in_wait",  1'b1, 32'h00A000F0, 2'd0, 2'd1, 1'b1, 20'h0ABCD, 4'b1000, 1'b0, 32'h0ABCD0F0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0));
        run_vec(mk("miss_aft_wflush",1'b1, 32'h00A000F0, 2'd0, 2'd1, 1'b1, 20'h0ABCE, 4'b1000, 1'b0, 32'h0ABCE0F0, 4'b1000, 1'b0));
        run_vec(mk("flush_at_fill",  1'b1, 32'h00B00010, 2'd0, 2'd1, 1'b1, 20'h0B0B0, 4'b1000, 1'b0, 32'h0B0B0010, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1));
        run_vec(mk("miss_aft_fflush",1'b1, 32'h00B00010, 2'd0, 2'd1, 1'b1, 20'h0B0B1, 4'b1000, 1'b0, 32'h0B0B1010, 4'b1000, 1'b0));
        run_vec(mk("flush_at_accept",1'b1, 32'h00B00020, 2'd0, 2'd1, 1'b0, 20'h0,     4'b0000, 1'b0, 32'h0B0B1020, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0));
        run_vec(mk("miss_aft_aflush",1'b1, 32'h00B00020, 2'd0, 2'd1, 1'b1, 20'h0B0B2, 4'b1000, 1'b0, 32'h0B0B2020, 4'b1000, 1'b0));

        // Reset while a walk request is pending, then a stale walk response in IDLE.
        run_vec(mk("fill_d", 1'b1, 32'h00D00000, 2'd0, 2'd1, 1'b1, 20'h0DDDD, 4'b1000, 1'b0, 32'h0DDDD000, 4'b1000, 1'b0));
        satp = 32'h8000_0000;
        bus.req_valid = 1'b1; bus.vaddr = 32'h00C00000; bus.acc_type = 2'd0; bus.cur_priv = 2'd1;
        tick();
        bus.req_valid = 1'b0;
        chk("rstwalk_pending", bus.walk_req_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rstwalk_walk_req", bus.walk_req_valid, 0);
        chk("rstwalk_req_ready", bus.req_ready, 1);
        chk("rstwalk_resp_valid", bus.resp_valid, 0);
        rst = 1'b0;
        bus.walk_rsp_valid = 1'b1; bus.walk_ppn = 20'h55555; bus.walk_err = 1'b0;
        {bus.walk_r, bus.walk_w, bus.walk_x, bus.walk_u} = 4'b1111;
        tick();
        bus.walk_rsp_valid = 1'b0;
        chk("stale_rsp_resp", bus.resp_valid, 0);
        chk("stale_rsp_ready", bus.req_ready, 1);
        tick();
        run_vec(mk("miss_after_rst", 1'b1, 32'h00D00004, 2'd0, 2'd1, 1'b1, 20'h0DDDE, 4'b1000, 1'b0, 32'h0DDDE004, 4'b1000, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
